// File: rtl/phy_rx_pkg.sv
// Shared types and widths for the serial receive path (framer + word assembly).
package phy_rx_pkg;

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} rx_state_e;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  localparam int BIT_CNT_W   = 3;
  localparam int COMMA_CNT_W = 4;
  localparam int BYTE_IDX_W  = 2;

endpackage

// File: rtl/phy_rx_byte_framer.sv
// Bit-granular comma hunt, byte alignment and lock for one serial lane.
// Emits a byte strobe every 8 bits once aligned; lock is sticky until reset.
module phy_rx_byte_framer
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEFAULT,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       locked
);

  localparam logic [BIT_CNT_W-1:0]   LAST_BIT = '1;
  localparam logic [COMMA_CNT_W-1:0] LOCK_CNT = COMMA_CNT_W'(LOCK_COUNT);

  rx_state_e                state, state_nxt;
  logic [7:0]               sr;
  logic [BIT_CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [COMMA_CNT_W-1:0]   comma_cnt, comma_cnt_nxt;
  logic                     comma_seen;

  assign comma_seen = (sr == COMMA);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= {sr[6:0], data_in};
      bit_cnt   <= bit_cnt_nxt;
      comma_cnt <= comma_cnt_nxt;
    end
  end

  // A match in SEARCH means sr already holds a whole comma, so the bit
  // sampled on that same edge is bit 0 of the next byte.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    comma_cnt_nxt = comma_cnt;
    case (state)
      SEARCH: begin
        bit_cnt_nxt = '0;
        if (comma_seen) begin
          comma_cnt_nxt = COMMA_CNT_W'(1);
          state_nxt     = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_nxt = bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
          if (comma_seen) begin
            comma_cnt_nxt = comma_cnt + 1'b1;
            if (comma_cnt + 1'b1 == LOCK_CNT) state_nxt = ACTIVE;
          end else begin
            comma_cnt_nxt = '0;
            bit_cnt_nxt   = '0;
            state_nxt     = SEARCH;
          end
        end
      end
      ACTIVE:  bit_cnt_nxt = bit_cnt + 1'b1;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    byte_stb = (state != SEARCH) && (bit_cnt == LAST_BIT);
    locked   = (state == ACTIVE);
    rx_byte  = sr;
  end

endmodule

// File: rtl/phy_rx_deserializer.sv
// Serial lane receiver: framer lock plus MSB-byte-first word assembly,
// with a one-cycle valid strobe per word and a pulse on truncated words.
module phy_rx_deserializer
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEFAULT,
  parameter int         LOCK_COUNT = 4,
  parameter int         WORD_BYTES = 4
) (
  input  logic                    clk_32f,
  input  logic                    reset,
  input  logic                    data_in,
  output logic [8*WORD_BYTES-1:0] data_out,
  output logic                    valid_out,
  output logic                    active,
  output logic                    word_err
);

  localparam int                    BUF_W    = 8 * (WORD_BYTES - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(WORD_BYTES - 1);

  logic [7:0]            rx_byte;
  logic                  byte_stb, locked, data_stb;
  logic [BUF_W-1:0]      word_buf;
  logic [BYTE_IDX_W-1:0] byte_idx;

  phy_rx_byte_framer #(
    .COMMA      (COMMA),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_framer (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .rx_byte  (rx_byte),
    .byte_stb (byte_stb),
    .locked   (locked)
  );

  assign active   = locked;
  assign data_stb = byte_stb & locked;

  // Earlier bytes shift up through word_buf, so the first byte lands in the MSBs.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      word_err  <= 1'b0;
      word_buf  <= '0;
      byte_idx  <= '0;
    end else begin
      valid_out <= 1'b0;
      word_err  <= 1'b0;
      if (data_stb) begin
        if (rx_byte == COMMA) begin
          if (byte_idx != '0) begin
            word_err <= 1'b1;
            byte_idx <= '0;
          end
        end else if (byte_idx == LAST_IDX) begin
          data_out  <= {word_buf, rx_byte};
          valid_out <= 1'b1;
          byte_idx  <= '0;
        end else begin
          word_buf <= {word_buf[BUF_W-9:0], rx_byte};
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for phy_rx_deserializer: lock, word table, slip, broken lock, async reset.
module tb_phy_rx_deserializer;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic        data_in;
  logic [31:0] data_out;
  logic        valid_out, active, word_err;

  phy_rx_deserializer dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .word_err  (word_err)
  );

  always #5 clk_32f = ~clk_32f;

  int cyc = 0;
  always @(posedge clk_32f) cyc <= cyc + 1;

  typedef struct {int cyc; logic [31:0] data;} ev_t;
  ev_t  vq[$];
  ev_t  eq[$];
  int   aq[$];
  logic act_q = 1'b0;
  int   both_cnt = 0;

  always @(negedge clk_32f) begin
    if (valid_out) vq.push_back('{cyc, data_out});
    if (word_err)  eq.push_back('{cyc, data_out});
    if (valid_out && word_err) both_cnt <= both_cnt + 1;
    if (active && !act_q) aq.push_back(cyc);
    act_q <= active;
  end

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[14];
  int   ends[14];
  int   checks = 0;
  int   errors = 0;
  int   last_edge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge; the next rising edge (number cyc+1) samples it.
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in   = b;
    last_edge = cyc + 1;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic commas(input int n);
    repeat (n) send(32'h000000BC, 8);
  endtask

  task automatic clear_logs();
    vq.delete();
    eq.delete();
    aq.delete();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    clear_logs();
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic expect_word(input string nm, input int edge_n, input logic [31:0] exp);
    ev_t ev;
    if (vq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got no valid_out pulse expected data %h", nm, exp);
    end else begin
      ev = vq.pop_front();
      chk({nm, " cycle"}, ev.cyc, edge_n + 1);
      chk({nm, " data"}, ev.data, exp);
    end
  endtask

  task automatic expect_lock(input string nm, input int edge_n);
    chk({nm, " rises"}, aq.size(), 1);
    if (aq.size() > 0) chk({nm, " cycle"}, aq[0], edge_n + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    ev_t         ev;
    int          lk, e;

    tbl[0]  = '{32'hDDDDDDDD, 32, 1'b1, 32'hDDDDDDDD, 1'b0};
    tbl[1]  = '{32'hEEEEEEEE, 32, 1'b1, 32'hEEEEEEEE, 1'b0};
    tbl[2]  = '{32'h000000BC,  8, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{32'h00000012,  8, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{32'h00000034,  8, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{32'h000000BC,  8, 1'b0, 32'h0,        1'b1};
    tbl[6]  = '{32'h99999999, 32, 1'b1, 32'h99999999, 1'b0};
    tbl[7]  = '{32'h00000000, 32, 1'b1, 32'h00000000, 1'b0};
    tbl[8]  = '{32'h000000BC,  8, 1'b0, 32'h0,        1'b0};
    tbl[9]  = '{32'h00000001,  8, 1'b0, 32'h0,        1'b0};
    tbl[10] = '{32'h00000002,  8, 1'b0, 32'h0,        1'b0};
    tbl[11] = '{32'h00000003,  8, 1'b0, 32'h0,        1'b0};
    tbl[12] = '{32'h000000BC,  8, 1'b0, 32'h0,        1'b1};
    tbl[13] = '{32'hFFFFFFFF, 32, 1'b1, 32'hFFFFFFFF, 1'b0};

    reset   = 1'b0;
    data_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("reset data_out", data_out, 32'h0);
    chk("reset valid_out", valid_out, 1'b0);
    chk("reset active", active, 1'b0);
    chk("reset word_err", word_err, 1'b0);

    // Lock: four commas; active must still be low right after the 32nd bit.
    do_reset();
    commas(4);
    lk = last_edge;
    @(posedge clk_32f); #1;
    chk("lock active early", active, 1'b0);
    chk("lock data_out", data_out, 32'h0);
    chk("lock no valid", vq.size(), 0);

    for (int i = 0; i < 14; i++) begin
      send(tbl[i].bits, tbl[i].nbits);
      ends[i] = last_edge;
    end
    commas(2);
    expect_lock("lock", lk);

    prev = 32'h0;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].exp_valid) begin
        expect_word($sformatf("vec%0d word", i), ends[i], tbl[i].exp_data);
        prev = tbl[i].exp_data;
      end
      if (tbl[i].exp_err) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL vec%0d word_err: got no pulse expected one", i);
        end else begin
          ev = eq.pop_front();
          chk($sformatf("vec%0d err cycle", i), ev.cyc, ends[i] + 1);
          chk($sformatf("vec%0d err data_out held", i), ev.data, prev);
        end
      end
    end
    chk("table extra valid", vq.size(), 0);
    chk("table extra err", eq.size(), 0);
    chk("valid and err together", both_cnt, 0);

    // Bit slip: three arbitrary bits ahead of the comma run.
    do_reset();
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    commas(4);
    lk = last_edge;
    send(32'h00000003, 32);
    e = last_edge;
    commas(1);
    expect_lock("slip lock", lk);
    expect_word("slip word", e, 32'h00000003);
    chk("slip data_out", data_out, 32'h00000003);

    // Broken lock: a non-comma after three commas restarts the hunt.
    do_reset();
    commas(3);
    send(32'h00000055, 8);
    @(posedge clk_32f); #1;
    chk("broken active", active, 1'b0);
    commas(4);
    lk = last_edge;
    send(32'hAAAAAAAA, 32);
    e = last_edge;
    commas(1);
    expect_lock("relock", lk);
    expect_word("relock word", e, 32'hAAAAAAAA);

    // Async reset mid-word, then a full comma run is needed again.
    send(32'h5A5A5A5A >> 20, 12);
    @(posedge clk_32f); #2;
    reset   = 1'b1;
    data_in = 1'b0;
    #1;
    chk("async data_out", data_out, 32'h0);
    chk("async active", active, 1'b0);
    chk("async valid_out", valid_out, 1'b0);
    chk("async word_err", word_err, 1'b0);
    repeat (2) @(posedge clk_32f);
    clear_logs();
    @(negedge clk_32f);
    reset = 1'b0;
    commas(3);
    @(posedge clk_32f); #1;
    chk("post-reset 3 commas active", active, 1'b0);
    commas(1);
    lk = last_edge;
    send(32'h5A5A5A5A, 32);
    e = last_edge;
    commas(1);
    expect_lock("post-reset lock", lk);
    expect_word("post-reset word", e, 32'h5A5A5A5A);
    chk("post-reset no err", eq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
